// File: rtl/lsu_v1.sv
// Load/store unit between the execute stage and a word-wide memory unit.
// Handles lane extraction/extension on loads, read-modify-write for sub-word stores, and access faults.
`timescale 1ns/1ps
module lsu_v1 #(
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [3:0]  MMIO_NIBBLE  = 4'hE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, ERR, RD, WR, RESP} state_t;

  state_t      state_reg;
  logic [2:0]  cnt_reg;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;

  logic        illegal;
  logic        misaligned;
  logic        mmio;
  logic        req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  // Fault classification on the live request, evaluated at accept time.
  always_comb begin
    illegal    = (req_funct3[1:0] == 2'b11) || (req_funct3[2] && (req_we || req_funct3[1]));
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    mmio       = (req_addr[31:28] >= MMIO_NIBBLE);
    req_err    = illegal || misaligned || (mmio && (req_funct3[1:0] != 2'b10));
  end

  always_comb begin
    byte_sel = mem_rdata[{addr_reg[1:0], 3'b000} +: 8];
    half_sel = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_reg[1:0])
      2'b00:   load_data = {{24{byte_sel[7] & ~funct3_reg[2]}}, byte_sel};
      2'b01:   load_data = {{16{half_sel[15] & ~funct3_reg[2]}}, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // Store merge: only the addressed lanes take new data, the rest keep the word just read.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       lane_hit;
      logic [7:0] lane_byte;
      always_comb begin
        case (funct3_reg[1:0])
          2'b00: begin
            lane_hit  = (addr_reg[1:0] == LANE);
            lane_byte = wdata_reg[7:0];
          end
          2'b01: begin
            lane_hit  = (addr_reg[1] == LANE[1]);
            lane_byte = wdata_reg[8*(gi%2) +: 8];
          end
          default: begin
            lane_hit  = 1'b1;
            lane_byte = wdata_reg[8*gi +: 8];
          end
        endcase
      end
      assign merged_word[8*gi +: 8] = lane_hit ? lane_byte : mem_rdata[8*gi +: 8];
    end
  endgenerate

  // Address is only presented while the memory is actually in use.
  assign mem_addr = ((state_reg == RD) || (state_reg == WR)) ? {addr_reg[31:2], 2'b00} : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      we_reg     <= 1'b0;
      funct3_reg <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      case (state_reg)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_reg     <= req_we;
            funct3_reg <= req_funct3;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            req_ready  <= 1'b0;
            cnt_reg    <= '0;
            if (req_err) begin
              state_reg  <= ERR;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
            end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
              state_reg <= WR;
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state_reg <= RD;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD: begin
          if (cnt_reg == 3'(READ_LATENCY - 1)) begin
            if (we_reg) begin
              state_reg <= WR;
              mem_we    <= 1'b1;
              mem_wdata <= merged_word;
            end else begin
              state_reg  <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= load_data;
            end
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
          end
        end
        WR: begin
          state_reg  <= RESP;
          resp_valid <= 1'b1;
        end
        RESP, ERR: begin
          state_reg <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_v1.sv
// Directed bench for lsu_v1: scoreboard of expected responses checked by a negedge monitor.
`timescale 1ns/1ps
module tb_lsu_v1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_v1 #(.READ_LATENCY(1), .MMIO_NIBBLE(4'hE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Memory model: data is valid within the one RD cycle (READ_LATENCY = 1).
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mem_we) begin
      wr_count++;
      last_wr_addr = mem_addr;
      last_wr_data = mem_wdata;
    end
    if (resp_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_resp: observed rdata %h err %b expected no response", resp_rdata, resp_error);
      end else begin
        e = sb.pop_front();
        $display("[TB] resp cyc=%0d rdata=%h err=%b (exp %h/%b @%0d)", cyc, resp_rdata, resp_error, e.rdata, e.err, e.cyc);
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_error", 32'(resp_error), 32'(e.err));
        chk("resp_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input int lat);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    if (!req_ready) return;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cyc   = cyc + lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  int wc;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[64] = 32'h8899AABB;   // 0x100
    mem[65] = 32'hCAFEF00D;   // 0x104
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
    rst = 1'b1;
    #2 rst = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // LW and the mem_addr it presents during RD
    send(1'b0, 3'b010, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 2);
    @(negedge clk);
    chk("lw_mem_addr", mem_addr, 32'h100);
    chk("lw_mem_we", 32'(mem_we), 32'd0);
    wait_done();

    send(1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF88, 1'b0, 2);
    wait_done();
    send(1'b0, 3'b100, 32'h103, 32'h0, 32'h00000088, 1'b0, 2);
    wait_done();
    send(1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF8899, 1'b0, 2);
    wait_done();
    send(1'b0, 3'b101, 32'h100, 32'h0, 32'h0000AABB, 1'b0, 2);
    wait_done();
    send(1'b0, 3'b100, 32'h101, 32'h0, 32'h000000AA, 1'b0, 2);
    wait_done();

    // SH read-modify-write
    wc = wr_count;
    send(1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 1'b0, 3);
    @(negedge clk);
    chk("sh_rd_mem_we", 32'(mem_we), 32'd0);
    chk("sh_rd_mem_addr", mem_addr, 32'h100);
    @(negedge clk);
    chk("sh_wr_mem_we", 32'(mem_we), 32'd1);
    chk("sh_wr_mem_wdata", mem_wdata, 32'h1234AABB);
    chk("sh_wr_mem_addr", mem_addr, 32'h100);
    wait_done();
    chk("sh_write_count", 32'(wr_count), 32'(wc + 1));

    send(1'b1, 3'b000, 32'h101, 32'h00000055, 32'h0, 1'b0, 3);
    wait_done();
    chk("sb_write_data", last_wr_data, 32'h123455BB);
    send(1'b0, 3'b010, 32'h100, 32'h0, 32'h123455BB, 1'b0, 2);
    wait_done();

    // Faults: no memory writes, one-cycle error response
    wc = wr_count;
    send(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1'b1, 1);
    wait_done();
    send(1'b1, 3'b000, 32'hFFFF0000, 32'h11, 32'h0, 1'b1, 1);
    wait_done();
    send(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1);
    wait_done();
    send(1'b1, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 1);
    wait_done();
    send(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1'b1, 1);
    wait_done();
    send(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1'b1, 1);
    wait_done();
    chk("err_no_writes", 32'(wr_count), 32'(wc));

    // MMIO word store
    wc = wr_count;
    send(1'b1, 3'b010, 32'hFFFF0000, 32'hFE000000, 32'h0, 1'b0, 2);
    @(negedge clk);
    chk("mmio_mem_addr", mem_addr, 32'hFFFF0000);
    chk("mmio_mem_we", 32'(mem_we), 32'd1);
    chk("mmio_mem_wdata", mem_wdata, 32'hFE000000);
    wait_done();
    chk("mmio_write_count", 32'(wr_count), 32'(wc + 1));
    chk("mmio_write_addr", last_wr_addr, 32'hFFFF0000);

    // Reset during the read phase of an SB
    wc = wr_count;
    send(1'b1, 3'b000, 32'h104, 32'h00000077, 32'h0, 1'b0, 3);
    @(negedge clk);
    chk("rmw_rd_mem_addr", mem_addr, 32'h104);
    rst = 1'b0;
    sb.delete();
    #1;
    chk("rst_mid_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_no_write", 32'(wr_count), 32'(wc));
    send(1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 1'b0, 2);
    wait_done();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_v1.md
Name: lsu_v1

Overview:
- Load/store unit sitting directly upstream of the memory unit. It accepts one load or store request at a time from the core's execute stage and drives the memory unit's word-wide mem_addr/data_in/write_enable interface.
- It performs RISC-V byte/halfword lane extraction with sign or zero extension on loads.
- Sub-word stores are done as read-modify-write, because the memory unit only supports full-word writes.
- It detects misaligned and illegal accesses and reports them without touching memory.

Parameters:
- READ_LATENCY, 1, cycles from mem_addr driven to mem_rdata valid; legal range 1..4.
- MMIO_NIBBLE, 4'hE, accesses with req_addr[31:28] >= MMIO_NIBBLE are memory-mapped I/O.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, low-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_error  output  1  misaligned/illegal access, valid with resp_valid.
- mem_addr  output  32  word-aligned address to memory unit.
- mem_wdata  output  32  write data to memory unit.
- mem_we  output  1  write strobe to memory unit.
- mem_rdata  input  32  read data from memory unit.

Behaviour:
- Reset (rst low, async): state IDLE, counter 0, all captured request fields 0. All outputs 0, including req_ready while rst is low. req_ready rises the first cycle after rst deasserts.
- Handshake: accept when req_valid && req_ready at a rising edge; capture req_we/funct3/addr/wdata. req_valid is ignored when req_ready is low. There is no response back-pressure; resp_valid is a one-cycle pulse.
- States: IDLE, ERR, RD, WR, RESP.
- Error check at accept, in priority order:
  - Illegal funct3 (loads 011/110/111; stores 011..111).
  - Misaligned: half accesses with addr[0]=1; word accesses with addr[1:0]!=0.
  - MMIO region with a sub-word access.
  - Any of these -> ERR: one cycle with resp_valid=1, resp_error=1, resp_rdata=0, then IDLE. mem_we stays 0 throughout.
- Load: IDLE -> RD.
  - RD holds mem_addr={addr[31:2],2'b00}, mem_we=0, for READ_LATENCY cycles.
  - mem_rdata is sampled at the final RD edge into the response register, then RESP.
  - Handshake-to-resp_valid latency = READ_LATENCY+1 cycles (2 by default).
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- SW (or any word store, including MMIO): IDLE -> WR.
  - WR lasts one cycle: mem_we=1, mem_wdata=req_wdata.
  - Then RESP. Latency = 2 cycles.
- SB/SH (non-MMIO): IDLE -> RD (read old word as for a load) -> WR -> RESP.
  - The merged word replaces only the addressed lane with req_wdata[7:0] or [15:0]; other lanes keep the read value.
  - Latency = READ_LATENCY+2.
- mem_addr:
  - Held constant at the aligned address from RD entry through WR; 0 in IDLE, RESP and ERR.
  - Exception: MMIO word accesses present the full req_addr, which is already aligned.
- mem_wdata is 0 outside WR. mem_we is high only in WR, exactly one cycle per store.
- RESP: resp_valid=1 for one cycle, resp_error=0, then IDLE. resp_rdata returns to 0 the cycle after.
- Reset mid-operation (any state): immediate return to IDLE.
  - mem_we drops asynchronously.
  - The in-flight request is discarded with no response; a partial RMW never writes.
- Back-to-back: a new request can be accepted in the first IDLE cycle after RESP/ERR. Minimum issue interval = latency + 1.

Test Plan:
- LW addr 0x100, memory holds 0x8899AABB at 0x100, READ_LATENCY=1 -> mem_addr=0x100 for 1 cycle; resp_valid 2 cycles after handshake with resp_rdata=0x8899AABB, resp_error=0.
- LB addr 0x103 and LBU addr 0x103, same word -> resp_rdata=0xFFFFFF88 and 0x00000088 respectively.
- SH addr 0x102, wdata 0x1234, old word 0x8899AABB -> one read, then a single mem_we pulse with mem_wdata=0x1234AABB at mem_addr 0x100; resp_valid at cycle 3.
- LW addr 0x101; then SB addr 0xFFFF0000 -> each gives resp_valid=1, resp_error=1 one cycle after accept; mem_we never asserted.
- SW addr 0xFFFF0000, wdata 0xFE000000 -> mem_addr=0xFFFF0000, mem_we=1 for exactly one cycle, resp_valid next cycle.
- SB in progress, rst pulled low during RD -> mem_we stays 0, no resp_valid; after release req_ready=1 and a following LW completes normally.
